// File: rtl/script_pkg.sv
// Shared definitions for the script executor: opcodes, instruction field layout,
// feedback-select codes, FSM state encoding and operate-byte formation.
package script_pkg;

    localparam logic [2:0] OP_ACT   = 3'd0;
    localparam logic [2:0] OP_TGT   = 3'd1;
    localparam logic [2:0] OP_WAITC = 3'd2;
    localparam logic [2:0] OP_WAITT = 3'd3;
    localparam logic [2:0] OP_JMP   = 3'd4;
    localparam logic [2:0] OP_JMPU  = 3'd5;
    localparam logic [2:0] OP_ILL   = 3'd6;
    localparam logic [2:0] OP_END   = 3'd7;

    localparam int OPC_LSB   = 0;
    localparam int OPC_MSB   = 2;
    localparam int SUB_LSB   = 3;
    localparam int SUB_MSB   = 4;
    localparam int POL_BIT   = 5;
    localparam int ARG_LSB   = 8;
    localparam int ARG_MSB   = 15;
    localparam int THROW_BIT = 7;

    localparam logic [7:0] OPERATE_THROW = 8'h10;

    localparam logic [1:0] SEL_FRONT      = 2'd0;
    localparam logic [1:0] SEL_HAND       = 2'd1;
    localparam logic [1:0] SEL_PROCESSING = 2'd2;
    localparam logic [1:0] SEL_MACHINE    = 2'd3;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FETCH     = 3'd1;
    localparam logic [2:0] ST_DECODE    = 3'd2;
    localparam logic [2:0] ST_HOLD      = 3'd3;
    localparam logic [2:0] ST_WAIT_COND = 3'd4;
    localparam logic [2:0] ST_WAIT_TIME = 3'd5;
    localparam logic [2:0] ST_DONE      = 3'd6;

    typedef struct packed {
        logic [7:0] arg;
        logic       pol;
        logic [1:0] sub;
        logic [2:0] opc;
    } instr_t;

    function automatic logic [7:0] operate_byte(input logic [1:0] sub, input logic [7:0] arg);
        if (arg[THROW_BIT]) begin
            return OPERATE_THROW;
        end
        return 8'h01 << sub;
    endfunction

endpackage

// File: rtl/script_decoder.sv
// Combinational instruction split, feedback-signal select/compare and
// operate-byte formation for the script executor.
module script_decoder
    import script_pkg::*;
(
    input  logic [15:0] script,
    input  logic [3:0]  sig,
    output logic [2:0]  opc,
    output logic [7:0]  arg,
    output logic        cond_met,
    output logic [7:0]  operate
);

    instr_t instr;
    logic   selected;
    logic   unused_reserved;

    always_comb begin
        instr.opc = script[OPC_MSB:OPC_LSB];
        instr.sub = script[SUB_MSB:SUB_LSB];
        instr.pol = script[POL_BIT];
        instr.arg = script[ARG_MSB:ARG_LSB];
    end

    // Bits between the polarity flag and the argument byte carry no meaning.
    assign unused_reserved = ^script[ARG_LSB-1:POL_BIT+1];

    always_comb begin
        selected = sig[0];
        case (instr.sub)
            SEL_FRONT:      selected = sig[0];
            SEL_HAND:       selected = sig[1];
            SEL_PROCESSING: selected = sig[2];
            SEL_MACHINE:    selected = sig[3];
            default:        selected = sig[0];
        endcase
    end

    assign opc      = instr.opc;
    assign arg      = instr.arg;
    assign cond_met = (selected == instr.pol);
    assign operate  = operate_byte(instr.sub, instr.arg);

endmodule

// File: rtl/script_executor.sv
// Script interpreter: walks the script memory, issues operate/target bytes to
// the UART send stage and gates progress on feedback signals and 1 ms ticks.
module script_executor
    import script_pkg::*;
#(
    parameter int HOLD_CYCLES = 16,
    parameter int TIMEOUT_MS  = 5000,
    parameter int PC_W        = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            script_mode,
    input  logic [15:0]     script,
    input  logic            tick_ms,
    input  logic            sig_front,
    input  logic            sig_hand,
    input  logic            sig_processing,
    input  logic            sig_machine,
    output logic [PC_W-1:0] pc,
    output logic [7:0]      data_operate,
    output logic [7:0]      data_target,
    output logic            running,
    output logic            done,
    output logic            error
);

    localparam int               HC_W        = $clog2(HOLD_CYCLES + 1);
    localparam logic [HC_W-1:0]  HOLD_LAST   = HC_W'(HOLD_CYCLES - 1);
    localparam logic [HC_W-1:0]  HOLD_GAP    = HC_W'(HOLD_CYCLES);
    localparam logic [15:0]      TIMEOUT_LIM = 16'(TIMEOUT_MS);
    localparam logic [PC_W-1:0]  PC_LAST     = '1;

    logic [2:0]      state;
    logic            start_q;
    logic            start_rise;
    logic [3:0]      sig_q;
    logic [HC_W-1:0] hold_cnt;
    logic [15:0]     ms_cnt;
    logic [15:0]     ms_inc;
    logic [2:0]      opc;
    logic [7:0]      arg;
    logic            cond_met;
    logic [7:0]      operate;
    logic            step;

    script_decoder u_decoder (
        .script   (script),
        .sig      (sig_q),
        .opc      (opc),
        .arg      (arg),
        .cond_met (cond_met),
        .operate  (operate)
    );

    assign start_rise = start & ~start_q;
    assign ms_inc     = (ms_cnt == 16'hFFFF) ? ms_cnt : ms_cnt + 16'd1;

    // step: current instruction finished, fall through to pc+1 (or end of memory).
    always_comb begin
        step = 1'b0;
        case (state)
            ST_DECODE: begin
                case (opc)
                    OP_TGT:   step = 1'b1;
                    OP_WAITT: step = (arg == 8'd0);
                    OP_JMP:   step = !cond_met;
                    default:  step = 1'b0;
                endcase
            end
            ST_HOLD:      step = (hold_cnt == HOLD_GAP);
            ST_WAIT_COND: step = cond_met;
            ST_WAIT_TIME: step = tick_ms && (ms_inc >= {8'd0, arg});
            default:      step = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            start_q      <= 1'b0;
            sig_q        <= '0;
            hold_cnt     <= '0;
            ms_cnt       <= '0;
            pc           <= '0;
            data_operate <= '0;
            data_target  <= '0;
            running      <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            start_q <= start;
            sig_q   <= {sig_machine, sig_processing, sig_hand, sig_front};
            if (script_mode) begin
                state        <= ST_IDLE;
                running      <= 1'b0;
                data_operate <= '0;
                pc           <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_rise) begin
                            state   <= ST_FETCH;
                            pc      <= '0;
                            done    <= 1'b0;
                            error   <= 1'b0;
                            running <= 1'b1;
                        end
                    end
                    ST_FETCH: state <= ST_DECODE;
                    ST_DECODE: begin
                        hold_cnt <= '0;
                        ms_cnt   <= '0;
                        case (opc)
                            OP_ACT: begin
                                data_operate <= operate;
                                state        <= ST_HOLD;
                            end
                            OP_TGT:   data_target <= {2'b00, arg[5:0]};
                            OP_WAITC: state <= ST_WAIT_COND;
                            OP_WAITT: state <= ST_WAIT_TIME;
                            OP_JMP: begin
                                if (cond_met) begin
                                    pc    <= PC_W'(arg);
                                    state <= ST_FETCH;
                                end
                            end
                            OP_JMPU: begin
                                pc    <= PC_W'(arg);
                                state <= ST_FETCH;
                            end
                            OP_ILL: begin
                                error <= 1'b1;
                                state <= ST_DONE;
                            end
                            OP_END: state <= ST_DONE;
                        endcase
                    end
                    // Operate byte is live for HOLD_CYCLES, then one idle cycle before moving on.
                    ST_HOLD: begin
                        if (hold_cnt == HOLD_LAST) begin
                            data_operate <= '0;
                            hold_cnt     <= HOLD_GAP;
                        end else if (hold_cnt != HOLD_GAP) begin
                            hold_cnt <= hold_cnt + HC_W'(1);
                        end
                    end
                    ST_WAIT_COND: begin
                        if (!cond_met && tick_ms) begin
                            if (ms_inc >= TIMEOUT_LIM) begin
                                error <= 1'b1;
                                state <= ST_DONE;
                            end else begin
                                ms_cnt <= ms_inc;
                            end
                        end
                    end
                    ST_WAIT_TIME: begin
                        if (tick_ms) begin
                            ms_cnt <= ms_inc;
                        end
                    end
                    ST_DONE: begin
                        running      <= 1'b0;
                        done         <= ~error;
                        data_operate <= '0;
                        state        <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
                if (step) begin
                    if (pc == PC_LAST) begin
                        state <= ST_DONE;
                    end else begin
                        pc    <= pc + PC_W'(1);
                        state <= ST_FETCH;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_script_executor.sv
// Bench for script_executor: directed scenarios plus random programs checked
// against an instruction-level interpreter of the script language.
`timescale 1ns/1ps
module tb_script_executor;

    localparam int HOLD = 16;
    localparam int TMO  = 10;

    localparam logic [2:0] C_ACT = 3'd0, C_TGT = 3'd1, C_WAITC = 3'd2, C_WAITT = 3'd3;
    localparam logic [2:0] C_JMP = 3'd4, C_JMPU = 3'd5, C_BAD = 3'd6, C_END = 3'd7;

    logic        clock = 1'b0;
    logic        reset, start, script_mode, tick_ms;
    logic        sig_front, sig_hand, sig_processing, sig_machine;
    logic [15:0] script;
    logic [7:0]  pc, data_operate, data_target;
    logic        running, done, error;

    logic [15:0] mem [256];
    int          checks = 0;
    int          errors = 0;

    logic [7:0]  run_val[$];
    int          run_len[$];
    logic [7:0]  cur_val;
    int          cur_len = 0;

    script_executor #(.HOLD_CYCLES(HOLD), .TIMEOUT_MS(TMO), .PC_W(8)) dut (
        .clock(clock), .reset(reset), .start(start), .script_mode(script_mode),
        .script(script), .tick_ms(tick_ms), .sig_front(sig_front), .sig_hand(sig_hand),
        .sig_processing(sig_processing), .sig_machine(sig_machine), .pc(pc),
        .data_operate(data_operate), .data_target(data_target), .running(running),
        .done(done), .error(error)
    );

    always #5 clock = ~clock;

    // Script memory with one cycle read latency.
    always @(posedge clock) script <= mem[pc];

    // Record every non-zero operate burst as (value, length in cycles).
    always @(negedge clock) begin
        if (data_operate != 8'd0) begin
            if (cur_len == 0) cur_val = data_operate;
            cur_len++;
        end else if (cur_len != 0) begin
            run_val.push_back(cur_val);
            run_len.push_back(cur_len);
            cur_len = 0;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] enc(input logic [2:0] opc, input logic [1:0] sub,
                                        input logic pol, input logic [7:0] arg);
        return {arg, 2'b00, pol, sub, opc};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = enc(C_END, 2'd0, 1'b0, 8'd0);
        run_val.delete();
        run_len.delete();
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic kick();
        @(negedge clock) start = 1'b0;
        @(negedge clock) start = 1'b1;
        @(negedge clock);
    endtask

    task automatic tick();
        @(negedge clock) tick_ms = 1'b1;
        @(negedge clock) tick_ms = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit expired);
        int n;
        n = 0;
        while (running === 1'b1 && n < budget) begin
            @(negedge clock);
            n++;
        end
        expired = (running === 1'b1);
    endtask

    task automatic test_reset();
        cycles(3);
        reset = 1'b0;
        checks++; if (pc !== 8'd0) begin errors++; $display("FAIL reset_pc: got %0h want 0", pc); end
        checks++; if ({data_operate, data_target} !== 16'd0) begin
            errors++; $display("FAIL reset_data: got %0h/%0h want 0/0", data_operate, data_target); end
        checks++; if ({running, done, error} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b want 000", {running, done, error}); end
    endtask

    task automatic test_basic();
        bit to;
        clear_mem();
        mem[0] = enc(C_TGT, 2'd0, 1'b0, 8'd3);
        mem[1] = enc(C_ACT, 2'd1, 1'b0, 8'd0);
        mem[2] = enc(C_END, 2'd0, 1'b0, 8'd0);
        kick();
        wait_idle(200, to);
        checks++; if (to) begin errors++; $display("FAIL basic_timeout: still running, want idle"); end
        checks++; if (data_target !== 8'h03) begin errors++; $display("FAIL basic_target: got %0h want 03", data_target); end
        checks++; if (run_val.size() != 1) begin errors++; $display("FAIL basic_bursts: got %0d want 1", run_val.size()); end
        if (run_val.size() >= 1) begin
            checks++; if (run_val[0] !== 8'h02) begin errors++; $display("FAIL basic_operate: got %0h want 02", run_val[0]); end
            checks++; if (run_len[0] != HOLD) begin errors++; $display("FAIL basic_hold: got %0d want %0d", run_len[0], HOLD); end
        end
        checks++; if ({done, error, running} !== 3'b100) begin
            errors++; $display("FAIL basic_flags: got done/err/run %b want 100", {done, error, running}); end
        checks++; if (pc !== 8'd2) begin errors++; $display("FAIL basic_pc: got %0d want 2", pc); end
    endtask

    task automatic test_waitc();
        bit to;
        clear_mem();
        sig_hand = 1'b0;
        mem[0] = enc(C_WAITC, 2'd1, 1'b1, 8'd0);
        kick();
        cycles(40);
        checks++; if ({pc, running} !== {8'd0, 1'b1}) begin
            errors++; $display("FAIL waitc_stall: got pc %0d run %b want pc 0 run 1", pc, running); end
        @(negedge clock) sig_hand = 1'b1;
        @(posedge clock) #1;
        checks++; if (pc !== 8'd0) begin errors++; $display("FAIL waitc_early: got pc %0d want 0", pc); end
        @(posedge clock) #1;
        checks++; if (pc !== 8'd1) begin errors++; $display("FAIL waitc_advance: got pc %0d want 1", pc); end
        wait_idle(50, to);
        checks++; if ({to, done, error} !== 3'b010) begin
            errors++; $display("FAIL waitc_end: got to/done/err %b want 010", {to, done, error}); end
        sig_hand = 1'b0;
    endtask

    task automatic test_waitt();
        bit to;
        clear_mem();
        mem[0] = enc(C_WAITT, 2'd0, 1'b0, 8'd3);
        mem[1] = enc(C_WAITT, 2'd0, 1'b0, 8'd0);
        kick();
        cycles(5);
        tick();
        checks++; if (pc !== 8'd0) begin errors++; $display("FAIL waitt_tick1: got pc %0d want 0", pc); end
        tick();
        checks++; if (pc !== 8'd0) begin errors++; $display("FAIL waitt_tick2: got pc %0d want 0", pc); end
        tick();
        checks++; if (pc !== 8'd1) begin errors++; $display("FAIL waitt_tick3: got pc %0d want 1", pc); end
        cycles(3);
        checks++; if (pc !== 8'd2) begin errors++; $display("FAIL waitt_zero: got pc %0d want 2", pc); end
        wait_idle(50, to);
        checks++; if ({to, done, error} !== 3'b010) begin
            errors++; $display("FAIL waitt_end: got to/done/err %b want 010", {to, done, error}); end
    endtask

    task automatic test_jmp();
        bit to;
        logic [7:0] want;
        for (int k = 0; k < 2; k++) begin
            clear_mem();
            mem[0]  = enc(C_JMP, 2'd0, 1'b1, 8'h10);
            sig_front = (k == 0);
            want = (k == 0) ? 8'h10 : 8'h01;
            cycles(2);
            kick();
            wait_idle(50, to);
            checks++; if ({to, pc, done} !== {1'b0, want, 1'b1}) begin
                errors++; $display("FAIL jmp_%0d: got to %b pc %0h done %b want to 0 pc %0h done 1", k, to, pc, done, want); end
        end
        sig_front = 1'b0;
    endtask

    task automatic test_timeout();
        bit to;
        clear_mem();
        sig_processing = 1'b0;
        mem[0] = enc(C_WAITC, 2'd2, 1'b1, 8'd0);
        kick();
        cycles(4);
        repeat (TMO - 1) tick();
        checks++; if ({error, running} !== 2'b01) begin
            errors++; $display("FAIL timeout_early: got err/run %b want 01", {error, running}); end
        tick();
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL timeout_error: got %b want 1", error); end
        wait_idle(20, to);
        checks++; if ({to, done, error, running} !== 4'b0010) begin
            errors++; $display("FAIL timeout_end: got to/done/err/run %b want 0010", {to, done, error, running}); end
    endtask

    task automatic test_illegal();
        bit to;
        clear_mem();
        mem[0] = enc(C_BAD, 2'd0, 1'b0, 8'd0);
        kick();
        wait_idle(20, to);
        checks++; if ({to, done, error, pc} !== {3'b001, 8'd0}) begin
            errors++; $display("FAIL illegal: got to/done/err %b pc %0d want 001 pc 0", {to, done, error}, pc); end
    endtask

    task automatic test_abort();
        bit to;
        int n;
        clear_mem();
        mem[0] = enc(C_ACT, 2'd3, 1'b0, 8'd0);
        kick();
        n = 0;
        while (data_operate == 8'd0 && n < 10) begin @(negedge clock); n++; end
        checks++; if (data_operate !== 8'h08) begin errors++; $display("FAIL abort_issue: got %0h want 08", data_operate); end
        cycles(3);
        @(negedge clock) script_mode = 1'b1;
        @(posedge clock) #1;
        checks++; if ({data_operate, running, pc} !== 17'd0) begin
            errors++; $display("FAIL abort_clear: got op %0h run %b pc %0d want 0/0/0", data_operate, running, pc); end
        @(negedge clock) script_mode = 1'b0;
        cycles(30);
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL abort_no_restart: got run %b want 0", running); end
        run_val.delete();
        run_len.delete();
        kick();
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL abort_restart: got run %b want 1", running); end
        wait_idle(100, to);
        checks++; if ({to, done, run_val.size() == 1} !== 3'b011) begin
            errors++; $display("FAIL abort_rerun: got to %b done %b bursts %0d want 0 1 1", to, done, run_val.size()); end
    endtask

    task automatic test_end_of_memory();
        bit to;
        clear_mem();
        mem[0]   = enc(C_JMPU, 2'd0, 1'b0, 8'hFF);
        mem[255] = enc(C_TGT, 2'd0, 1'b0, 8'h05);
        kick();
        wait_idle(100, to);
        checks++; if ({to, pc, done, error} !== {1'b0, 8'hFF, 2'b10}) begin
            errors++; $display("FAIL eom_stop: got to %b pc %0h done %b err %b want 0 ff 1 0", to, pc, done, error); end
        checks++; if (data_target !== 8'h05) begin errors++; $display("FAIL eom_target: got %0h want 05", data_target); end
    endtask

    task automatic test_random();
        bit          to;
        int          len, kind, mpc, nsteps;
        logic [3:0]  sg;
        logic [7:0]  a, mtgt, eo;
        logic [1:0]  s, rsv;
        logic        p;
        logic [2:0]  op;
        logic [15:0] w;
        logic [7:0]  exp_ops[$];
        for (int t = 0; t < 20; t++) begin
            clear_mem();
            len = $urandom_range(12, 3);
            sg  = 4'($urandom);
            for (int i = 0; i < len - 1; i++) begin
                kind = (i == 0) ? 1 : $urandom_range(3, 0);
                a    = 8'($urandom);
                s    = 2'($urandom);
                p    = 1'($urandom);
                rsv  = 2'($urandom);
                if (kind >= 2) a = 8'($urandom_range(len - 1, i + 1));
                op = (kind == 0) ? C_ACT : (kind == 1) ? C_TGT : (kind == 2) ? C_JMP : C_JMPU;
                mem[i] = {a, rsv, p, s, op};
            end
            mem[len - 1] = enc(C_END, 2'd0, 1'b0, 8'($urandom));
            // Interpret the program one instruction at a time.
            mpc = 0; mtgt = 8'd0; nsteps = 0;
            exp_ops.delete();
            while (nsteps < 300) begin
                w = mem[mpc];
                if (w[2:0] == C_END) break;
                s = w[4:3]; p = w[5]; a = w[15:8];
                case (w[2:0])
                    C_ACT:   begin eo = a[7] ? 8'h10 : (8'h01 << s); exp_ops.push_back(eo); mpc++; end
                    C_TGT:   begin mtgt = {2'b00, a[5:0]}; mpc++; end
                    C_JMP:   mpc = (sg[s] == p) ? int'(a) : mpc + 1;
                    default: mpc = int'(a);
                endcase
                nsteps++;
            end
            {sig_machine, sig_processing, sig_hand, sig_front} = sg;
            cycles(2);
            kick();
            wait_idle(2000, to);
            checks++; if (to) begin errors++; $display("FAIL rnd%0d_timeout: still running, want idle", t); end
            checks++; if (pc !== 8'(mpc)) begin errors++; $display("FAIL rnd%0d_pc: got %0d want %0d", t, pc, mpc); end
            checks++; if ({done, error} !== 2'b10) begin
                errors++; $display("FAIL rnd%0d_flags: got done/err %b want 10", t, {done, error}); end
            checks++; if (data_target !== mtgt) begin errors++; $display("FAIL rnd%0d_target: got %0h want %0h", t, data_target, mtgt); end
            checks++; if (run_val.size() != exp_ops.size()) begin
                errors++; $display("FAIL rnd%0d_bursts: got %0d want %0d", t, run_val.size(), exp_ops.size()); end
            for (int i = 0; i < exp_ops.size() && i < run_val.size(); i++) begin
                checks++; if (run_val[i] !== exp_ops[i] || run_len[i] != HOLD) begin
                    errors++; $display("FAIL rnd%0d_op%0d: got %0h x%0d want %0h x%0d", t, i, run_val[i], run_len[i], exp_ops[i], HOLD); end
            end
        end
        {sig_machine, sig_processing, sig_hand, sig_front} = 4'd0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; script_mode = 1'b0; tick_ms = 1'b0;
        sig_front = 1'b0; sig_hand = 1'b0; sig_processing = 1'b0; sig_machine = 1'b0;
        clear_mem();
        test_reset();
        test_basic();
        test_waitc();
        test_waitt();
        test_jmp();
        test_timeout();
        test_illegal();
        test_abort();
        test_end_of_memory();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
